// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator and its adder sub-module.
package sum_acc_pkg;

  localparam int SUM_W_DEF = 17;
  localparam int ACC_W_DEF = 20;
  localparam int CNT_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_acc_sat_add.sv
// Combinational (ACC_W+1)-bit add of the running total and a zero-extended sample.
// Clamps to all-ones on carry when SUM_ACC_SAT_EN is defined; wraps otherwise.
module sum_acc_sat_add
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [SUM_W-1:0] i_sample,
  output logic [ACC_W-1:0] o_acc_next,
  output logic             o_carry
);

  logic [ACC_W:0] w_sum;

  assign w_sum   = {1'b0, i_acc} + (ACC_W+1)'(i_sample);
  assign o_carry = w_sum[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // A clamped total stays clamped: any further non-zero sample carries again.
  assign o_acc_next = o_carry ? '1 : w_sum[ACC_W-1:0];
`else
  assign o_acc_next = w_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder samples and presents the total over valid/ready.
// Optional saturation is selected by the SUM_ACC_SAT_EN macro (see sum_acc_sat_add).
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             ovf,
  output state_t           dbg_state
);

  // Output handshake: acc_out/ovf are final while acc_valid is high; the result is
  // consumed at a rising edge where acc_valid && acc_ready, and acc_valid may not
  // drop before that edge.

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_acc_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_acc_next;
  logic             w_carry;

  sum_acc_sat_add #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W)
  ) u_add (
    .i_acc      (r_acc),
    .i_sample   (sum_in),
    .o_acc_next (w_acc_next),
    .o_carry    (w_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= num_samples;
            r_busy <= 1'b1;
            // A zero-length run skips accumulation and reports a zero total.
            if (num_samples == '0) begin
              r_state     <= DONE;
              r_acc_valid <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (sum_valid) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state     <= DONE;
              r_acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            r_state     <= IDLE;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = r_acc;
  assign acc_valid = r_acc_valid;
  assign busy      = r_busy;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised scoreboard bench for sum_accumulator: the driver pushes the expected
// total of each run, a negedge monitor pops and compares on every output handshake.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int SW = SUM_W_DEF;
  localparam int AW = ACC_W_DEF;
  localparam int CW = CNT_W_DEF;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_samples;
  logic [SW-1:0] sum_in;
  logic          sum_valid;
  logic          acc_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          busy;
  logic          ovf;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;

  // Each entry is {ovf, acc_out} for one completed run.
  logic [AW:0]   exp_q[$];
  logic [AW-1:0] hold_val;
  logic          hold_seen = 1'b0;

  sum_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_samples (num_samples),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .acc_ready   (acc_ready),
    .acc_out     (acc_out),
    .acc_valid   (acc_valid),
    .busy        (busy),
    .ovf         (ovf),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: true integer sum of the run, then overflow/wrap/clamp rules.
  function automatic logic [AW:0] model(input logic [SW-1:0] s[$]);
    longint     total;
    logic       m_ovf;
    logic [AW-1:0] m_acc;
    total = 0;
    foreach (s[i]) total += longint'(s[i]);
    m_ovf = (total >= (longint'(1) << AW));
`ifdef SUM_ACC_SAT_EN
    m_acc = m_ovf ? {AW{1'b1}} : AW'(total);
`else
    m_acc = AW'(total % (longint'(1) << AW));
`endif
    return {m_ovf, m_acc};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [AW:0] e;
    if (reset && acc_valid) begin
      if (!hold_seen) begin
        hold_val  = acc_out;
        hold_seen = 1'b1;
      end else begin
        chk("acc_out_stable", 32'(acc_out), 32'(hold_val));
      end
      if (acc_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got acc_out %h with nothing expected at %0t",
                   acc_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("acc_out", 32'(acc_out), 32'(e[AW-1:0]));
          chk("ovf", 32'(ovf), 32'(e[AW]));
        end
        hold_seen = 1'b0;
      end
    end else begin
      hold_seen = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run(input logic [SW-1:0] s[$], input int gap_pct, input int ready_wait);
    exp_q.push_back(model(s));
    start       = 1'b1;
    num_samples = CW'(s.size());
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    foreach (s[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        sum_valid = 1'b0;
        sum_in    = SW'($urandom);
        start     = 1'($urandom_range(1));
        acc_ready = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
      sum_valid = 1'b1;
      sum_in    = s[i];
      start     = 1'($urandom_range(1));
      acc_ready = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    sum_valid = 1'b0;
    start     = 1'b0;
    acc_ready = 1'b0;
    chk("acc_valid_latency", 32'(acc_valid), 32'd1);
    repeat (ready_wait) begin
      start     = 1'($urandom_range(1));
      sum_valid = 1'($urandom_range(1));
      sum_in    = SW'($urandom);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    sum_valid = 1'b0;
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    chk("acc_valid_cleared", 32'(acc_valid), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("state_idle_after_hs", 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] s[$];
    int n;

    reset       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    sum_in      = '0;
    sum_valid   = 1'b0;
    acc_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Basic four-sample run.
    s = '{17'h00001, 17'h00002, 17'h1FFFF, 17'h00004};
    run(s, 0, 0);

    // Gapped samples with backpressure.
    s = '{17'h00010, 17'h00010, 17'h00010};
    run(s, 50, 5);

    // Nine maximum samples overflow the accumulator.
    s.delete();
    repeat (9) s.push_back(17'h1FFFF);
    run(s, 0, 1);

    // Zero-length run.
    s.delete();
    run(s, 0, 2);

    // Reset in the middle of a run: no result may appear.
    start       = 1'b1;
    num_samples = CW'(10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      sum_valid = 1'b1;
      sum_in    = 17'h1FFFF;
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_acc_valid", 32'(acc_valid), 32'd0);
    chk("midrst_acc_out", 32'(acc_out), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    sum_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sum_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sum_valid = 1'b0;
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_valid", 32'(acc_valid), 32'd0);

    // Maximum-length run.
    s.delete();
    repeat (127) s.push_back(SW'($urandom));
    run(s, 10, 1);

    // Random runs.
    repeat (25) begin
      s.delete();
      n = ($urandom_range(3) == 0) ? int'($urandom_range(127)) : int'($urandom_range(12));
      repeat (n) begin
        if ($urandom_range(3) == 0) s.push_back(17'h1FFFF);
        else s.push_back(SW'($urandom));
      end
      run(s, int'($urandom_range(40)), int'($urandom_range(4)));
    end

    @(posedge clk); #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
